// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- hazard and pipeline-control unit for a 5-stage in-order core.
//
// Decides every cycle whether the front end stalls, which pipeline registers
// are flushed, and whether the whole pipe is frozen behind a slow data-memory
// access. Control outputs are combinational from the registered state and the
// current inputs; the pipeline registers act on them at the next rising edge.
//
// Priority within a cycle: memory freeze > branch redirect > load-use stall.
//
// Parameters
//   FLUSH_CYCLES  cycles IF/ID is flushed after a taken branch (1..7)
//   TIMEOUT       memory wait cycles before mem_timeout is raised (1..1023)
//
// Ports
//   clk              clock, all state updates on the rising edge
//   rst              synchronous active-low reset
//   id_rs1, id_rs2   source registers of the instruction in ID
//   id_use_rs1/rs2   ID instruction actually reads rs1 / rs2
//   ex_is_load       instruction in EX is a load
//   ex_rd            destination register of the instruction in EX
//   ex_branch_taken  EX resolved a taken branch/jump this cycle
//   mem_req          MEM stage is accessing data memory
//   dmem_ready       data memory completes the access this cycle
//   pc_stall         hold the PC
//   ifid_stall       hold the IF/ID register
//   ifid_flush       squash the IF/ID register
//   idex_flush       insert a bubble into ID/EX
//   pipe_freeze      freeze every pipeline register
//   pc_redirect      load the PC with the branch target
//   state            controller state (RUN=0, MEM_WAIT=1, FLUSH=2)
//   mem_timeout      sticky: a memory access waited TIMEOUT cycles
//   stall_cnt        saturating count of cycles with pc_stall asserted
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        dmem_ready,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        pipe_freeze,
    output logic        pc_redirect,
    output logic [1:0]  state,
    output logic        mem_timeout,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_FLUSH    = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [9:0] TIMEOUT_CNT  = 10'(TIMEOUT);

    state_t      cur_state, nxt_state;
    logic [9:0]  wait_cnt, wait_nxt;
    logic [2:0]  flush_cnt, flush_nxt;
    logic        load_use;
    logic        mem_stall;
    logic        run_rules;

    // x0 is hard-wired zero, so a load "writing" it never creates a hazard.
    assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    assign mem_stall = mem_req && !dmem_ready;

    assign state = cur_state;

    // Next-state and control decode.
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_freeze = 1'b0;
        pc_redirect = 1'b0;
        nxt_state   = cur_state;
        wait_nxt    = wait_cnt;
        flush_nxt   = flush_cnt;
        run_rules   = 1'b0;

        case (cur_state)
            S_MEM_WAIT: begin
                if (!dmem_ready) begin
                    // EX is held, so a branch or load-use it shows now will be
                    // presented again once memory completes.
                    pipe_freeze = 1'b1;
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    wait_nxt    = (wait_cnt == 10'h3FF) ? wait_cnt : wait_cnt + 10'd1;
                end else begin
                    wait_nxt  = 10'd0;
                    nxt_state = S_RUN;
                    run_rules = 1'b1;
                end
            end

            S_FLUSH: begin
                if (mem_stall) begin
                    // Freeze wins; the remaining flush count is dropped and
                    // the controller resumes in RUN after the access.
                    pipe_freeze = 1'b1;
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    nxt_state   = S_MEM_WAIT;
                    wait_nxt    = 10'd1;
                    flush_nxt   = 3'd0;
                end else begin
                    // The ID instruction is being discarded, so load-use is
                    // irrelevant here.
                    ifid_flush = 1'b1;
                    if (ex_branch_taken) begin
                        pc_redirect = 1'b1;
                        idex_flush  = 1'b1;
                        flush_nxt   = FLUSH_RELOAD;
                    end else if (flush_cnt <= 3'd1) begin
                        nxt_state = S_RUN;
                        flush_nxt = 3'd0;
                    end else begin
                        flush_nxt = flush_cnt - 3'd1;
                    end
                end
            end

            // RUN, and the unused encoding 3 which recovers to RUN.
            default: begin
                nxt_state = S_RUN;
                if (mem_stall) begin
                    pipe_freeze = 1'b1;
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    nxt_state   = S_MEM_WAIT;
                    wait_nxt    = 10'd1;
                end else begin
                    run_rules = 1'b1;
                end
            end
        endcase

        // Branch / load-use decision shared by RUN and the MEM_WAIT exit cycle.
        if (run_rules) begin
            if (ex_branch_taken) begin
                pc_redirect = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    nxt_state = S_FLUSH;
                    flush_nxt = FLUSH_RELOAD;
                end
            end else if (load_use) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
            end
        end

        // While reset is held nothing may stall or flush the pipeline.
        if (!rst) begin
            pc_stall    = 1'b0;
            ifid_stall  = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            pipe_freeze = 1'b0;
            pc_redirect = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_state   <= S_RUN;
            wait_cnt    <= 10'd0;
            flush_cnt   <= 3'd0;
            mem_timeout <= 1'b0;
            stall_cnt   <= 32'd0;
        end else begin
            cur_state <= nxt_state;
            wait_cnt  <= wait_nxt;
            flush_cnt <= flush_nxt;
            // Raised together with wait_cnt reaching TIMEOUT; sticky until reset.
            if ((nxt_state == S_MEM_WAIT) && (wait_nxt == TIMEOUT_CNT))
                mem_timeout <= 1'b1;
            if (pc_stall && (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl -- scoreboard bench for pipe_ctrl (FLUSH_CYCLES=3, TIMEOUT=8).
//
// The driver applies one directed vector per cycle just after the rising edge
// and pushes the hand-computed expected outputs for that cycle. A monitor on
// the falling edge pops each entry and compares it against the DUT.
// Expected stall_cnt is accumulated from the expected pc_stall of each vector.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam logic [5:0] C_NONE = 6'b000000;
    // Bit order: {pc_stall, ifid_stall, ifid_flush, idex_flush, pipe_freeze, pc_redirect}
    localparam logic [5:0] C_LU   = 6'b110100;
    localparam logic [5:0] C_FRZ  = 6'b110010;
    localparam logic [5:0] C_BR   = 6'b001101;
    localparam logic [5:0] C_FL   = 6'b001000;

    typedef struct packed {
        logic       rst;
        logic       ld;
        logic [4:0] rd;
        logic       use1;
        logic [4:0] rs1;
        logic       use2;
        logic [4:0] rs2;
        logic       br;
        logic       mreq;
        logic       rdy;
    } stim_t;

    typedef struct packed {
        logic [5:0]  ctrl;
        logic [1:0]  st;
        logic        tmo;
        logic [31:0] scnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_is_load;
    logic        ex_branch_taken, mem_req, dmem_ready;
    logic        pc_stall, ifid_stall, ifid_flush, idex_flush, pipe_freeze, pc_redirect;
    logic [1:0]  state;
    logic        mem_timeout;
    logic [31:0] stall_cnt;

    exp_t        sb[$];
    string       name_q[$];
    logic [31:0] exp_scnt = 32'd0;
    int          n_checks = 0;
    int          n_fail   = 0;

    pipe_ctrl #(.FLUSH_CYCLES(3), .TIMEOUT(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_is_load      (ex_is_load),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .dmem_ready      (dmem_ready),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .pipe_freeze     (pipe_freeze),
        .pc_redirect     (pc_redirect),
        .state           (state),
        .mem_timeout     (mem_timeout),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic stim_t stim(input logic r, input logic ld, input logic [4:0] rd,
                                   input logic u1, input logic [4:0] s1,
                                   input logic u2, input logic [4:0] s2,
                                   input logic br, input logic mreq, input logic rdy);
        stim_t s;
        s.rst = r;   s.ld = ld;   s.rd = rd;
        s.use1 = u1; s.rs1 = s1;  s.use2 = u2; s.rs2 = s2;
        s.br = br;   s.mreq = mreq; s.rdy = rdy;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply one vector for the coming cycle and queue its expected response.
    task automatic drive(input string name, input stim_t s, input logic [5:0] ctrl,
                         input logic [1:0] st, input logic tmo);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = s.rst;
        ex_is_load      = s.ld;
        ex_rd           = s.rd;
        id_use_rs1      = s.use1;
        id_rs1          = s.rs1;
        id_use_rs2      = s.use2;
        id_rs2          = s.rs2;
        ex_branch_taken = s.br;
        mem_req         = s.mreq;
        dmem_ready      = s.rdy;
        e.ctrl = ctrl;
        e.st   = st;
        e.tmo  = tmo;
        e.scnt = exp_scnt;
        sb.push_back(e);
        name_q.push_back(name);
        if (!s.rst)       exp_scnt = 32'd0;
        else if (ctrl[5]) exp_scnt = exp_scnt + 32'd1;
    endtask

    // Monitor: compares every cycle for which an expectation is queued.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t  e;
            string n;
            e = sb.pop_front();
            n = name_q.pop_front();
            check({n, ".ctrl"}, 32'({pc_stall, ifid_stall, ifid_flush, idex_flush,
                                    pipe_freeze, pc_redirect}), 32'(e.ctrl));
            check({n, ".state"}, 32'(state), 32'(e.st));
            check({n, ".mem_timeout"}, 32'(mem_timeout), 32'(e.tmo));
            check({n, ".stall_cnt"}, stall_cnt, e.scnt);
        end
    end

    initial begin
        stim_t idle, br, memw, memhit, lu5;
        idle   = stim(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        br     = stim(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        memw   = stim(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        memhit = stim(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        lu5    = stim(1, 1, 5, 1, 5, 0, 0, 0, 0, 0);

        rst = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_is_load = 1'b0;
        ex_branch_taken = 1'b0; mem_req = 1'b0; dmem_ready = 1'b0;

        // Reset holds every control output low even with all hazards present.
        drive("rst_gate", stim(0, 1, 5, 1, 5, 0, 0, 1, 1, 0), C_NONE, 2'd0, 1'b0);
        drive("idle",     idle, C_NONE, 2'd0, 1'b0);

        // Load-use detection.
        drive("lu_rd0",      stim(1, 1, 0, 1, 0, 0, 0, 0, 0, 0), C_NONE, 2'd0, 1'b0);
        drive("lu_rs1",      lu5,  C_LU,   2'd0, 1'b0);
        drive("lu_gone",     idle, C_NONE, 2'd0, 1'b0);
        drive("lu_rs2",      stim(1, 1, 7, 0, 7, 1, 7, 0, 0, 0), C_LU,   2'd0, 1'b0);
        drive("lu_nouse",    stim(1, 1, 7, 0, 7, 0, 7, 0, 0, 0), C_NONE, 2'd0, 1'b0);
        drive("lu_noload",   stim(1, 0, 7, 1, 7, 1, 7, 0, 0, 0), C_NONE, 2'd0, 1'b0);
        drive("lu_mismatch", stim(1, 1, 7, 1, 6, 1, 8, 0, 0, 0), C_NONE, 2'd0, 1'b0);

        // Branch with a 3-cycle IF/ID flush; load-use ignored while flushing.
        drive("br_run",     br,   C_BR,   2'd0, 1'b0);
        drive("flush1",     idle, C_FL,   2'd2, 1'b0);
        drive("flush2_lu",  lu5,  C_FL,   2'd2, 1'b0);
        drive("flush_done", idle, C_NONE, 2'd0, 1'b0);

        // Branch beats load-use; a new branch in FLUSH reloads the count.
        drive("br_over_lu", stim(1, 1, 5, 1, 5, 0, 0, 1, 0, 0), C_BR, 2'd0, 1'b0);
        drive("flush_rebr", br,   C_BR,   2'd2, 1'b0);
        drive("flush_a",    idle, C_FL,   2'd2, 1'b0);
        drive("flush_b",    idle, C_FL,   2'd2, 1'b0);
        drive("run_again",  idle, C_NONE, 2'd0, 1'b0);

        // Four frozen cycles, then completion with a branch redirects.
        drive("mw_enter",   memw, C_FRZ, 2'd0, 1'b0);
        drive("mw_2",       memw, C_FRZ, 2'd1, 1'b0);
        drive("mw_3_br",    stim(1, 0, 0, 0, 0, 0, 0, 1, 1, 0), C_FRZ, 2'd1, 1'b0);
        drive("mw_4_lu",    stim(1, 1, 5, 1, 5, 0, 0, 0, 1, 0), C_FRZ, 2'd1, 1'b0);
        drive("mw_done_br", stim(1, 0, 0, 0, 0, 0, 0, 1, 1, 1), C_BR,  2'd1, 1'b0);
        drive("mw_fl1",     idle, C_FL,   2'd2, 1'b0);
        drive("mw_fl2",     idle, C_FL,   2'd2, 1'b0);
        drive("mw_run",     idle, C_NONE, 2'd0, 1'b0);

        // Freeze beats branch in RUN; load-use resolved on the exit cycle.
        drive("frz_over_br", stim(1, 0, 0, 0, 0, 0, 0, 1, 1, 0), C_FRZ, 2'd0, 1'b0);
        drive("mw_done_lu",  stim(1, 1, 5, 1, 5, 0, 0, 0, 1, 1), C_LU,  2'd1, 1'b0);
        drive("mw_lu_run",   idle, C_NONE, 2'd0, 1'b0);

        // Memory stall during FLUSH drops the flush and resumes in RUN.
        drive("fm_br",   br,     C_BR,   2'd0, 1'b0);
        drive("fm_frz",  memw,   C_FRZ,  2'd2, 1'b0);
        drive("fm_rdy",  memhit, C_NONE, 2'd1, 1'b0);
        drive("fm_run",  idle,   C_NONE, 2'd0, 1'b0);
        drive("mem_hit", memhit, C_NONE, 2'd0, 1'b0);

        // Timeout after 8 wait cycles; sticky after completion.
        drive("to_enter", memw, C_FRZ, 2'd0, 1'b0);
        for (int i = 0; i < 7; i++)
            drive("to_wait", memw, C_FRZ, 2'd1, 1'b0);
        drive("to_hit",    memw,   C_FRZ,  2'd1, 1'b1);
        drive("to_hold",   memw,   C_FRZ,  2'd1, 1'b1);
        drive("to_rdy",    memhit, C_NONE, 2'd1, 1'b1);
        drive("to_sticky", idle,   C_NONE, 2'd0, 1'b1);

        // Reset mid-FLUSH (flush_cnt=2) clears everything, no residual flush.
        drive("rf_br",    br,   C_BR,   2'd0, 1'b1);
        drive("rf_rst",   stim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), C_NONE, 2'd2, 1'b1);
        drive("rf_after", idle, C_NONE, 2'd0, 1'b0);

        // Reset mid-MEM_WAIT abandons the freeze.
        drive("rm_enter", memw, C_FRZ,  2'd0, 1'b0);
        drive("rm_rst",   stim(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), C_NONE, 2'd1, 1'b0);
        drive("rm_after", idle, C_NONE, 2'd0, 1'b0);
        drive("rm_idle",  idle, C_NONE, 2'd0, 1'b0);

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 4; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        #1;
        check("scoreboard_drain", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, number of cycles IF/ID is flushed after a taken branch (range 1..7).
REQ-002 SHALL have parameter TIMEOUT, default 255, data-memory wait cycles before mem_timeout is raised (range 1..1023).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-006 SHALL have ports id_use_rs1, id_use_rs2  input  1 each  the ID instruction reads rs1 / rs2.
REQ-007 SHALL have ports ex_is_load  input  1 and ex_rd  input  5  describing the instruction in EX.
REQ-008 SHALL have port ex_branch_taken  input  1  EX resolved a taken branch or jump this cycle.
REQ-009 SHALL have ports mem_req  input  1 and dmem_ready  input  1  the MEM-stage access and its completion.
REQ-010 SHALL have outputs pc_stall, ifid_stall, ifid_flush, idex_flush, pipe_freeze, pc_redirect  1 each  pipeline control.
REQ-011 SHALL have outputs state  2 (RUN=0, MEM_WAIT=1, FLUSH=2), mem_timeout  1, stall_cnt  32.

Function
REQ-012 Control outputs SHALL be combinational from registered state and current inputs; pipeline registers act on them at the next edge.
REQ-013 Priority within a cycle SHALL be: memory freeze > branch redirect > load-use > none.
REQ-014 Load-use hazard SHALL be ex_is_load && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
REQ-015 RUN, mem_req && !dmem_ready: pipe_freeze=pc_stall=ifid_stall=1, all flushes 0; next state MEM_WAIT; wait_cnt<=1.
REQ-016 RUN, else ex_branch_taken: pc_redirect=ifid_flush=idex_flush=1; next state FLUSH if FLUSH_CYCLES>1 (flush_cnt<=FLUSH_CYCLES-1), else RUN.
REQ-017 RUN, else load-use: pc_stall=ifid_stall=idex_flush=1 for exactly one cycle; state stays RUN.
REQ-018 RUN, none of the above: all control outputs 0.
REQ-019 MEM_WAIT: pipe_freeze=pc_stall=ifid_stall=1 while dmem_ready=0; ex_branch_taken and load-use ignored (EX is held and re-presents them).
REQ-020 MEM_WAIT, dmem_ready=1: outputs as RUN without the memory term, same cycle; next state per REQ-016/017 rules, else RUN.
REQ-021 wait_cnt (10 bits) SHALL increment each MEM_WAIT cycle with dmem_ready=0, saturating at 1023; cleared on leaving MEM_WAIT.
REQ-022 mem_timeout SHALL set when wait_cnt==TIMEOUT in MEM_WAIT and stay set (sticky) until reset; pipeline remains frozen.
REQ-023 FLUSH: ifid_flush=1 each cycle; flush_cnt decrements; state returns to RUN the cycle after flush_cnt reaches 1.
REQ-024 FLUSH, new ex_branch_taken: pc_redirect=idex_flush=1 and flush_cnt reloads FLUSH_CYCLES-1.
REQ-025 FLUSH: load-use SHALL NOT stall (ID instruction is being discarded).
REQ-026 FLUSH, mem_req && !dmem_ready: freeze per REQ-015 overrides; flush_cnt discarded; after MEM_WAIT, return to RUN.
REQ-027 stall_cnt SHALL increment on every cycle with pc_stall=1, saturating at 0xFFFFFFFF.
REQ-028 Illegal state encoding 3 SHALL behave as RUN and transition to RUN.

Reset
REQ-029 rst=0 at a rising edge SHALL force state=RUN, wait_cnt=0, flush_cnt=0, mem_timeout=0, stall_cnt=0.
REQ-030 During reset all control outputs SHALL be 0; reset mid-MEM_WAIT or mid-FLUSH SHALL abandon the operation with no residual stall.

Verification
REQ-031 ex_is_load=1, ex_rd=5, id_use_rs1=1, id_rs1=5 for one cycle -> pc_stall=ifid_stall=idex_flush=1 that cycle only, stall_cnt=1.
REQ-032 ex_rd=0 with matching id_rs1=0, ex_is_load=1 -> no stall, stall_cnt stays 0.
REQ-033 FLUSH_CYCLES=3, ex_branch_taken pulse -> pc_redirect 1 cycle, ifid_flush 3 consecutive cycles, state 0->2->2->0.
REQ-034 mem_req=1, dmem_ready=0 for 4 cycles then 1 with ex_branch_taken=1 -> freeze 4 cycles, redirect on 5th, stall_cnt=4.
REQ-035 TIMEOUT=8, dmem_ready held 0 -> mem_timeout rises after 8th wait cycle, persists after dmem_ready=1 until rst=0.
REQ-036 rst=0 mid-FLUSH with flush_cnt=2 -> next cycle state=RUN, ifid_flush=0, stall_cnt=0.
